fd_pipe_reg: RTL and testbench
==============================

FD_PIPE_REG -- requirements
Module: fd_pipe_reg

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-003 SHALL have port f_predPC, input, 64: next predicted PC from the PC-prediction logic.
REQ-004 SHALL have ports f_icode/f_ifun, input, 4 each: fetched instruction code and function.
REQ-005 SHALL have ports f_rA/f_rB, input, 4 each: fetched register IDs; 0xF means none.
REQ-006 SHALL have ports f_valC/f_valP, input, 64 each: fetched constant and incremented PC.
REQ-007 SHALL have port f_stat, input, 2: fetch status, one of AOK/HLT/ADR/INS.
REQ-008 SHALL have ports F_stall, D_stall, D_bubble, input, 1 each: hazard control from pipeline control logic.
REQ-009 SHALL have port F_predPC, output, 64: registered predicted PC feeding PC selection.
REQ-010 SHALL have ports D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, output, widths as the f_* inputs: decode-stage register.
REQ-011 SHALL have port fetch_halted, output, 1: fetch frozen after a non-AOK fetch.
REQ-012 SHALL have port ctrl_err, output, 1: sticky flag for an illegal control combination.
REQ-013 SHALL have ports cnt_stall and cnt_bubble, output, 32 each: performance counters.

Function
REQ-014 F_predPC SHALL load f_predPC each cycle when F_stall=0 and fetch_halted=0; otherwise it SHALL hold.
REQ-015 D_stall=1 SHALL hold all D_* outputs unchanged.
REQ-016 D_bubble=1 with D_stall=0 SHALL load a NOP: icode=1, ifun=0, rA=rB=0xF, valC=0, valP=0, stat=AOK.
REQ-017 With D_stall=0 and D_bubble=0, D_* SHALL load f_* with one-cycle latency.
REQ-018 When D_stall=1 and D_bubble=1 together, stall SHALL win (hold) and ctrl_err SHALL set and stay set until reset.
REQ-019 fetch_halted SHALL set on the edge where f_stat!=AOK is loaded into D.
REQ-020 fetch_halted SHALL clear on any D_bubble=1 cycle (squash of a mispredicted path).
REQ-021 If a set and a clear of fetch_halted occur in the same cycle, clear SHALL win.
REQ-022 While fetch_halted=1, D SHALL still obey stall/bubble, and a non-bubble load SHALL load f_* unchanged.
REQ-023 F_stall=1 with D_stall=0 is legal; each register SHALL obey only its own control.

Reset
REQ-024 On rst=1 at a clock edge: F_predPC=0, D SHALL hold the NOP of REQ-016, fetch_halted=0, ctrl_err=0, and both counters=0.
REQ-025 rst SHALL override every stall, bubble and halt condition in the same cycle.

Configuration
REQ-026 Macro FD_PERF_CNT_EN defined: cnt_stall SHALL increment on each cycle with D_stall=1, and cnt_bubble on each cycle with D_bubble=1 and D_stall=0; both SHALL saturate at 0xFFFFFFFF.
REQ-027 Macro FD_PERF_CNT_EN undefined: the counter registers SHALL NOT exist, and cnt_stall and cnt_bubble SHALL be constant 0.

Structure
REQ-028 Shared package y86_pkg SHALL hold the icode constants (IHALT=0, INOP=1 … IRET=9, IPUSHQ=10, IPOPQ=11), the stat codes (SAOK=1, SHLT=2, SADR=3, SINS=4) and RNONE=0xF.
REQ-029 The D-stage fields SHALL be implemented with one sub-module, pipe_reg_field: a parameterised-width register with stall, bubble value and reset value.

Verification
REQ-030 Reset, then f_predPC=0x14 with no controls -> next cycle F_predPC=0x14; D receives the f_* values one cycle later.
REQ-031 F_stall=1 for 3 cycles while f_predPC changes -> F_predPC holds 0x14, then updates on the first cycle after release.
REQ-032 D_bubble=1 with f_icode=6 -> D_icode=1, D_rA=0xF, D_stat=SAOK; cnt_bubble=1 when FD_PERF_CNT_EN is defined, 0 when undefined.
REQ-033 D_stall=1 and D_bubble=1 together -> D holds its previous values, ctrl_err=1 and stays 1 after the controls drop.
REQ-034 f_stat=SINS loaded -> fetch_halted=1 and F_predPC frozen; a later D_bubble=1 -> fetch_halted=0 and F_predPC resumes.
REQ-035 Hold D_stall=1 with the counter preset near saturation -> cnt_stall stops at 0xFFFFFFFF; rst mid-stall -> all outputs at their reset values next cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the fetch/decode bundle.
// The 2-bit stat field carries the low two bits of the stat code.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int SAOK = 1;
    localparam int SHLT = 2;
    localparam int SADR = 3;
    localparam int SINS = 4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int STAT_W = 2;
    typedef logic [STAT_W-1:0] stat_t;

    // SINS wraps to 2'b00; only AOK (2'b01) counts as a clean fetch.
    localparam stat_t ST_AOK = stat_t'(SAOK);
    localparam stat_t ST_HLT = stat_t'(SHLT);
    localparam stat_t ST_ADR = stat_t'(SADR);
    localparam stat_t ST_INS = stat_t'(SINS);

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        stat_t       stat;
    } d_reg_t;

    localparam d_reg_t D_NOP = '{
        icode: INOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  64'h0,
        valp:  64'h0,
        stat:  ST_AOK
    };

endpackage

// File: rtl/fd_pipe_reg_field.sv
// Generic pipeline register with stall, bubble value and reset value.
// Priority: reset, then stall (hold), then bubble, then load.
module pipe_reg_field #(
    parameter int           W       = 64,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] bubble_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold on stall, inject bubble_val on bubble, else load d.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (!stall)
            q <= bubble ? bubble_val : d;
    end

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline registers (F_predPC and the D bundle).
// Optional perf counters: define FD_PERF_CNT_EN.
module fd_pipe_reg
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] f_predPC,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [1:0]  f_stat,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [63:0] F_predPC,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [1:0]  D_stat,
    output logic        fetch_halted,
    output logic        ctrl_err,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_bubble
);

    localparam int DW = $bits(d_reg_t);

    d_reg_t f_bus;
    d_reg_t d_bus;
    logic   fetch_hold;

    assign f_bus = '{
        icode: f_icode,
        ifun:  f_ifun,
        ra:    f_rA,
        rb:    f_rB,
        valc:  f_valC,
        valp:  f_valP,
        stat:  f_stat
    };

    assign fetch_hold = F_stall | fetch_halted;

    pipe_reg_field #(
        .W       (64),
        .RST_VAL (64'h0)
    ) u_f_pc (
        .clk        (clk),
        .rst        (rst),
        .stall      (fetch_hold),
        .bubble     (1'b0),
        .bubble_val (64'h0),
        .d          (f_predPC),
        .q          (F_predPC)
    );

    pipe_reg_field #(
        .W       (DW),
        .RST_VAL (D_NOP)
    ) u_d (
        .clk        (clk),
        .rst        (rst),
        .stall      (D_stall),
        .bubble     (D_bubble),
        .bubble_val (D_NOP),
        .d          (f_bus),
        .q          (d_bus)
    );

    assign D_icode = d_bus.icode;
    assign D_ifun  = d_bus.ifun;
    assign D_rA    = d_bus.ra;
    assign D_rB    = d_bus.rb;
    assign D_valC  = d_bus.valc;
    assign D_valP  = d_bus.valp;
    assign D_stat  = d_bus.stat;

    // Freeze fetch once a faulting fetch reaches D; a squash unfreezes.
    always_ff @(posedge clk) begin
        if (rst)
            fetch_halted <= 1'b0;
        else if (D_bubble)
            fetch_halted <= 1'b0;
        else if (!D_stall && f_stat != ST_AOK)
            fetch_halted <= 1'b1;
    end

    // Sticky flag: stall and bubble asserted together.
    always_ff @(posedge clk) begin
        if (rst)
            ctrl_err <= 1'b0;
        else if (D_stall && D_bubble)
            ctrl_err <= 1'b1;
    end

`ifdef FD_PERF_CNT_EN
    logic [31:0] cnt_stall_q;
    logic [31:0] cnt_bubble_q;

    // Saturating stall / effective-bubble counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_stall_q  <= 32'h0;
            cnt_bubble_q <= 32'h0;
        end else begin
            if (D_stall && cnt_stall_q != 32'hFFFF_FFFF)
                cnt_stall_q <= cnt_stall_q + 32'h1;
            if (D_bubble && !D_stall && cnt_bubble_q != 32'hFFFF_FFFF)
                cnt_bubble_q <= cnt_bubble_q + 32'h1;
        end
    end

    assign cnt_stall  = cnt_stall_q;
    assign cnt_bubble = cnt_bubble_q;
`else
    assign cnt_stall  = 32'h0;
    assign cnt_bubble = 32'h0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Self-checking bench for fd_pipe_reg with a behavioural model.
// Counter expectations follow FD_PERF_CNT_EN.
module tb_fd_pipe_reg;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] f_predPC;
    d_reg_t      f_bus;
    logic        F_stall, D_stall, D_bubble;
    logic [63:0] F_predPC;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [1:0]  D_stat;
    logic        fetch_halted, ctrl_err;
    logic [31:0] cnt_stall, cnt_bubble;
    d_reg_t      d_obs;

    always #5 clk = ~clk;

    fd_pipe_reg dut (
        .clk          (clk),
        .rst          (rst),
        .f_predPC     (f_predPC),
        .f_icode      (f_bus.icode),
        .f_ifun       (f_bus.ifun),
        .f_rA         (f_bus.ra),
        .f_rB         (f_bus.rb),
        .f_valC       (f_bus.valc),
        .f_valP       (f_bus.valp),
        .f_stat       (f_bus.stat),
        .F_stall      (F_stall),
        .D_stall      (D_stall),
        .D_bubble     (D_bubble),
        .F_predPC     (F_predPC),
        .D_icode      (D_icode),
        .D_ifun       (D_ifun),
        .D_rA         (D_rA),
        .D_rB         (D_rB),
        .D_valC       (D_valC),
        .D_valP       (D_valP),
        .D_stat       (D_stat),
        .fetch_halted (fetch_halted),
        .ctrl_err     (ctrl_err),
        .cnt_stall    (cnt_stall),
        .cnt_bubble   (cnt_bubble)
    );

    assign d_obs = {D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat};

    int checks = 0;
    int errors = 0;

    logic [63:0]     m_pc;
    d_reg_t          m_d;
    logic            m_halt, m_err;
    longint unsigned m_ns, m_nb;

    function automatic logic [31:0] sat32(input longint unsigned n);
        return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
    endfunction

    function automatic logic [31:0] exp_cs();
`ifdef FD_PERF_CNT_EN
        return sat32(m_ns);
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_cb();
`ifdef FD_PERF_CNT_EN
        return sat32(m_nb);
`else
        return 32'h0;
`endif
    endfunction

    function automatic d_reg_t rand_f(input logic aok);
        d_reg_t f;
        f.icode = 4'($urandom);
        f.ifun  = 4'($urandom);
        f.ra    = 4'($urandom);
        f.rb    = 4'($urandom);
        f.valc  = {$urandom, $urandom};
        f.valp  = {$urandom, $urandom};
        f.stat  = aok ? ST_AOK : 2'($urandom);
        return f;
    endfunction

    // Apply inputs at negedge, clock once, advance the model, end at negedge.
    task automatic step(input logic r, input logic fs, input logic ds,
                        input logic db, input d_reg_t f,
                        input logic [63:0] pc);
        rst      = r;
        F_stall  = fs;
        D_stall  = ds;
        D_bubble = db;
        f_bus    = f;
        f_predPC = pc;
        @(posedge clk);
        if (r) begin
            m_pc   = 64'h0;
            m_d    = D_NOP;
            m_halt = 1'b0;
            m_err  = 1'b0;
            m_ns   = 0;
            m_nb   = 0;
        end else begin
            if (!fs && !m_halt)
                m_pc = pc;
            if (ds && db)
                m_err = 1'b1;
            if (ds)
                m_ns++;
            else if (db)
                m_nb++;
            if (db)
                m_halt = 1'b0;
            else if (!ds && f.stat != ST_AOK)
                m_halt = 1'b1;
            if (!ds)
                m_d = db ? D_NOP : f;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, rand_f(1'b0), 64'hDEAD);
        step(1'b1, 1'b0, 1'b1, 1'b1, rand_f(1'b0), 64'hBEEF);
        checks++;
        if (F_predPC !== 64'h0) begin
            errors++;
            $display("FAIL reset_pc got %h want 0", F_predPC);
        end
        checks++;
        if (d_obs !== D_NOP) begin
            errors++;
            $display("FAIL reset_d got %h want %h", d_obs, D_NOP);
        end
        checks++;
        if (fetch_halted !== 1'b0 || ctrl_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b want 00",
                     fetch_halted, ctrl_err);
        end
        checks++;
        if (cnt_stall !== 32'h0 || cnt_bubble !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h/%h want 0/0",
                     cnt_stall, cnt_bubble);
        end
    endtask

    task automatic test_basic();
        d_reg_t f;
        f = rand_f(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, f, 64'h14);
        checks++;
        if (F_predPC !== 64'h14) begin
            errors++;
            $display("FAIL basic_pc got %h want 14", F_predPC);
        end
        checks++;
        if (d_obs !== f) begin
            errors++;
            $display("FAIL basic_d got %h want %h", d_obs, f);
        end
    endtask

    task automatic test_f_stall();
        d_reg_t f;
        for (int i = 0; i < 3; i++) begin
            f = rand_f(1'b1);
            step(1'b0, 1'b1, 1'b0, 1'b0, f, {$urandom, $urandom});
            checks++;
            if (F_predPC !== 64'h14) begin
                errors++;
                $display("FAIL fstall_hold got %h want 14", F_predPC);
            end
            checks++;
            if (d_obs !== f) begin
                errors++;
                $display("FAIL fstall_d got %h want %h", d_obs, f);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_f(1'b1), 64'h40);
        checks++;
        if (F_predPC !== 64'h40) begin
            errors++;
            $display("FAIL fstall_release got %h want 40", F_predPC);
        end
    endtask

    task automatic test_bubble();
        d_reg_t f;
        f = rand_f(1'b1);
        f.icode = IOPQ;
        step(1'b0, 1'b0, 1'b0, 1'b1, f, 64'h48);
        checks++;
        if (D_icode !== INOP || D_rA !== RNONE || D_stat !== ST_AOK) begin
            errors++;
            $display("FAIL bubble_nop got %h/%h/%h want 1/f/1",
                     D_icode, D_rA, D_stat);
        end
        checks++;
        if (d_obs !== D_NOP) begin
            errors++;
            $display("FAIL bubble_d got %h want %h", d_obs, D_NOP);
        end
        checks++;
`ifdef FD_PERF_CNT_EN
        if (cnt_bubble !== 32'd1) begin
            errors++;
            $display("FAIL bubble_cnt got %0d want 1", cnt_bubble);
        end
`else
        if (cnt_bubble !== 32'd0) begin
            errors++;
            $display("FAIL bubble_cnt got %0d want 0", cnt_bubble);
        end
`endif
    endtask

    task automatic test_conflict();
        d_reg_t prev;
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_f(1'b1), 64'h50);
        prev = d_obs;
        step(1'b0, 1'b0, 1'b1, 1'b1, rand_f(1'b1), 64'h58);
        checks++;
        if (d_obs !== prev) begin
            errors++;
            $display("FAIL conflict_hold got %h want %h", d_obs, prev);
        end
        checks++;
        if (ctrl_err !== 1'b1) begin
            errors++;
            $display("FAIL conflict_err got %b want 1", ctrl_err);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_f(1'b1), 64'h60);
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_f(1'b1), 64'h68);
        checks++;
        if (ctrl_err !== 1'b1) begin
            errors++;
            $display("FAIL conflict_sticky got %b want 1", ctrl_err);
        end
    endtask

    task automatic test_halt();
        d_reg_t f;
        f = rand_f(1'b1);
        f.stat = ST_INS;
        step(1'b0, 1'b0, 1'b0, 1'b0, f, 64'h100);
        checks++;
        if (fetch_halted !== 1'b1 || d_obs !== f) begin
            errors++;
            $display("FAIL halt_set got %b/%h want 1/%h",
                     fetch_halted, d_obs, f);
        end
        f = rand_f(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, f, 64'h200);
        checks++;
        if (F_predPC !== 64'h100 || d_obs !== f) begin
            errors++;
            $display("FAIL halt_freeze got %h/%h want 100/%h",
                     F_predPC, d_obs, f);
        end
        f.stat = ST_ADR;
        step(1'b0, 1'b0, 1'b0, 1'b1, f, 64'h300);
        checks++;
        if (fetch_halted !== 1'b0 || F_predPC !== 64'h100) begin
            errors++;
            $display("FAIL halt_clear got %b/%h want 0/100",
                     fetch_halted, F_predPC);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_f(1'b1), 64'h308);
        checks++;
        if (F_predPC !== 64'h308) begin
            errors++;
            $display("FAIL halt_resume got %h want 308", F_predPC);
        end
    endtask

    task automatic test_random();
        logic r, fs, ds, db;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            fs = ($urandom_range(0, 3) == 0);
            ds = ($urandom_range(0, 3) == 0);
            db = ($urandom_range(0, 4) == 0);
            step(r, fs, ds, db, rand_f($urandom_range(0, 3) != 0),
                 {$urandom, $urandom});
            checks++;
            if (F_predPC !== m_pc) begin
                errors++;
                $display("FAIL rnd_pc[%0d] got %h want %h", i, F_predPC, m_pc);
            end
            checks++;
            if (d_obs !== m_d) begin
                errors++;
                $display("FAIL rnd_d[%0d] got %h want %h", i, d_obs, m_d);
            end
            checks++;
            if (fetch_halted !== m_halt || ctrl_err !== m_err) begin
                errors++;
                $display("FAIL rnd_flags[%0d] got %b%b want %b%b", i,
                         fetch_halted, ctrl_err, m_halt, m_err);
            end
            checks++;
            if (cnt_stall !== exp_cs() || cnt_bubble !== exp_cb()) begin
                errors++;
                $display("FAIL rnd_cnt[%0d] got %h/%h want %h/%h", i,
                         cnt_stall, cnt_bubble, exp_cs(), exp_cb());
            end
        end
    endtask

    task automatic test_sat_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, rand_f(1'b1), 64'h0);
`ifdef FD_PERF_CNT_EN
        dut.cnt_stall_q = 32'hFFFF_FFFD;
        m_ns = 64'hFFFF_FFFD;
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, rand_f(1'b1), 64'h10);
            checks++;
            if (cnt_stall !== exp_cs()) begin
                errors++;
                $display("FAIL sat_cnt[%0d] got %h want %h",
                         i, cnt_stall, exp_cs());
            end
        end
`ifdef FD_PERF_CNT_EN
        checks++;
        if (cnt_stall !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_top got %h want ffffffff", cnt_stall);
        end
`endif
        step(1'b1, 1'b1, 1'b1, 1'b1, rand_f(1'b0), 64'h99);
        checks++;
        if (F_predPC !== 64'h0 || d_obs !== D_NOP) begin
            errors++;
            $display("FAIL sat_rst got %h/%h want 0/%h",
                     F_predPC, d_obs, D_NOP);
        end
        checks++;
        if (fetch_halted || ctrl_err || cnt_stall !== 0 || cnt_bubble !== 0)
        begin
            errors++;
            $display("FAIL sat_rst_misc got %b%b %h %h want 00 0 0",
                     fetch_halted, ctrl_err, cnt_stall, cnt_bubble);
        end
    endtask

    initial begin
        rst      = 1'b1;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        f_bus    = D_NOP;
        f_predPC = 64'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_f_stall();
        test_bubble();
        test_conflict();
        test_halt();
        test_random();
        test_sat_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
